node_nic: RTL and testbench

Local network interface for one hierarchical-ring node. It sits between a core/cache agent and a `nodeRouter` instance, and owns both local ports of that router. Injection: it buffers core flits per local port and drives them onto `portl0_ci`/`portl1_ci` until the router acks. Ejection: it captures every valid flit the router delivers on `portl0_co`/`portl1_co` and hands them to the core through one valid/ready stream.

---
 rtl/node_nic_pkg.sv | 9 +
 rtl/nic_fifo.sv | 43 ++++
 rtl/node_nic.sv | 83 ++++++++
 tb/tb_node_nic.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/node_nic_pkg.sv
// Shared flit geometry for the node NIC (mirrors the ring-wide defines.v layout).
// Flit width and valid-bit position; no NIC-private constants beyond the drop counter width.
package node_nic_pkg;
  localparam int CONTROL_W = 144;
  localparam int VALID_BIT = CONTROL_W - 1;
  localparam int DROP_W    = 16;

  typedef logic [CONTROL_W-1:0] flit_t;
endpackage

// File: rtl/nic_fifo.sv
// Generic FIFO with a combinational head, zero when empty.
// Latency: a push at edge k is visible on head after edge k when the FIFO was empty.
// Backpressure: a push is taken while not full, or while full and popped at the same edge.
module nic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full and popped together, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/node_nic.sv
// Node NIC: buffers core flits onto the router's two local ports, merges ejected flits to one stream.
// Latency: one edge from push to portlN_ci / ej_flit when the flit is at the head and granted.
// Backpressure: inj_ready per selected port; ejection overflow drops flits and counts them.
module node_nic
  import node_nic_pkg::*;
#(
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CONTROL_W-1:0] inj_flit,
  input  logic                 inj_port,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  output logic [CONTROL_W-1:0] portl0_ci,
  output logic [CONTROL_W-1:0] portl1_ci,
  input  logic                 portl0_ack,
  input  logic                 portl1_ack,
  input  logic [CONTROL_W-1:0] portl0_co,
  input  logic [CONTROL_W-1:0] portl1_co,
  output logic [CONTROL_W-1:0] ej_flit,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [DROP_W-1:0]    drop_cnt
);
  logic  [1:0] inj_full, inj_empty, inj_push;
  logic  [1:0] ej_full, ej_empty, ej_push, ej_pop, drop;
  flit_t       ej_head0, ej_head1;
  logic        rr, grant;
  logic  [1:0] drop_sum;
  logic  [DROP_W:0] drop_next;

  assign inj_ready = !inj_full[inj_port];
  assign inj_push  = (inj_valid && inj_ready) ? (inj_port ? 2'b10 : 2'b01) : 2'b00;

  nic_fifo #(.WIDTH(CONTROL_W), .DEPTH(INJ_DEPTH)) u_inj0 (
    .clk(clk), .rst(rst), .push(inj_push[0]), .push_dat(inj_flit),
    .pop(portl0_ack), .head(portl0_ci), .full(inj_full[0]), .empty(inj_empty[0])
  );

  nic_fifo #(.WIDTH(CONTROL_W), .DEPTH(INJ_DEPTH)) u_inj1 (
    .clk(clk), .rst(rst), .push(inj_push[1]), .push_dat(inj_flit),
    .pop(portl1_ack), .head(portl1_ci), .full(inj_full[1]), .empty(inj_empty[1])
  );

  assign ej_push = {portl1_co[VALID_BIT], portl0_co[VALID_BIT]};

  nic_fifo #(.WIDTH(CONTROL_W), .DEPTH(EJ_DEPTH)) u_ej0 (
    .clk(clk), .rst(rst), .push(ej_push[0]), .push_dat(portl0_co),
    .pop(ej_pop[0]), .head(ej_head0), .full(ej_full[0]), .empty(ej_empty[0])
  );

  nic_fifo #(.WIDTH(CONTROL_W), .DEPTH(EJ_DEPTH)) u_ej1 (
    .clk(clk), .rst(rst), .push(ej_push[1]), .push_dat(portl1_co),
    .pop(ej_pop[1]), .head(ej_head1), .full(ej_full[1]), .empty(ej_empty[1])
  );

  // Preferred FIFO wins when it has data; otherwise the other one.
  always_comb begin
    grant = rr;
    if (rr == 1'b0) grant = ej_empty[0] ? 1'b1 : 1'b0;
    else            grant = ej_empty[1] ? 1'b0 : 1'b1;
  end

  assign ej_valid = !(ej_empty[0] && ej_empty[1]);
  assign ej_flit  = !ej_valid ? '0 : (grant ? ej_head1 : ej_head0);
  assign ej_pop   = (ej_valid && ej_ready) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign drop      = ej_push & ej_full & ~ej_pop;
  assign drop_sum  = {1'b0, drop[0]} + {1'b0, drop[1]};
  assign drop_next = {1'b0, drop_cnt} + {{(DROP_W-1){1'b0}}, drop_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (ej_valid && ej_ready) rr <= ~grant;
      drop_cnt <= drop_next[DROP_W] ? {DROP_W{1'b1}} : drop_next[DROP_W-1:0];
    end
  end
endmodule

// File: tb/tb_node_nic.sv
// Directed bench for node_nic: injection, ejection arbitration, overflow and async reset.
module tb_node_nic;
  import node_nic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  flit_t       inj_flit, portl0_ci, portl1_ci, portl0_co, portl1_co, ej_flit;
  logic        inj_port, inj_valid, inj_ready, portl0_ack, portl1_ack;
  logic        ej_valid, ej_ready;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  node_nic #(.INJ_DEPTH(4), .EJ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inj_flit(inj_flit), .inj_port(inj_port), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .portl0_ci(portl0_ci), .portl1_ci(portl1_ci),
    .portl0_ack(portl0_ack), .portl1_ack(portl1_ack),
    .portl0_co(portl0_co), .portl1_co(portl1_co),
    .ej_flit(ej_flit), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [CONTROL_W-1:0] got,
                       input logic [CONTROL_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input logic [15:0] id);
    return {1'b1, 127'b0, id};
  endfunction

  flit_t a_flit;

  initial begin
    rst = 1'b1; inj_flit = '0; inj_port = 1'b0; inj_valid = 1'b0;
    portl0_ack = 1'b0; portl1_ack = 1'b0; portl0_co = '0; portl1_co = '0;
    ej_ready = 1'b0;
    a_flit = 144'h0a00000000000000000000000000000f1853;
    tick(); tick();
    check("rst_ci0", portl0_ci, '0);
    check("rst_ci1", portl1_ci, '0);
    check("rst_ej_flit", ej_flit, '0);
    check("rst_ej_valid", ej_valid, 0);
    check("rst_inj_ready", inj_ready, 1);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Single injection, held until ack
    inj_flit = a_flit; inj_port = 1'b0; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("inj_hold%0d", i), portl0_ci, a_flit);
      if (i < 2) tick();
    end
    check("inj_ci1_idle", portl1_ci, '0);
    portl0_ack = 1'b1;
    tick();
    portl0_ack = 1'b0;
    #1 check("inj_after_ack", portl0_ci, '0);

    // Fill injection FIFO 0, then drain back-to-back
    for (int i = 0; i < 4; i++) begin
      inj_flit = mk(16'h0100 + 16'(i)); inj_port = 1'b0; inj_valid = 1'b1;
      #1 check($sformatf("fill_ready%0d", i), inj_ready, 1);
      tick();
    end
    inj_valid = 1'b0;
    #1 check("fill_full_p0", inj_ready, 0);
    inj_port = 1'b1;
    #1 check("fill_ready_p1", inj_ready, 1);
    check("fill_head", portl0_ci, mk(16'h0100));
    portl0_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("drain%0d", i), portl0_ci, (i == 4) ? '0 : mk(16'h0100 + 16'(i)));
    end
    tick();
    check("ack_empty_ignored", portl0_ci, '0);
    portl0_ack = 1'b0;

    // Port 1 injection
    inj_flit = mk(16'h0200); inj_port = 1'b1; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    #1 check("inj_p1", portl1_ci, mk(16'h0200));
    portl1_ack = 1'b1;
    tick();
    portl1_ack = 1'b0;
    #1 check("inj_p1_ack", portl1_ci, '0);

    // Simultaneous ejection, twice, to show rr returns to port 0
    ej_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      portl0_co = mk(16'h0B00 + 16'(r)); portl1_co = mk(16'h0C00 + 16'(r));
      tick();
      portl0_co = '0; portl1_co = '0;
      #1 check($sformatf("ej_first%0d", r), ej_flit, mk(16'h0B00 + 16'(r)));
      check($sformatf("ej_vld%0d", r), ej_valid, 1);
      tick();
      check($sformatf("ej_second%0d", r), ej_flit, mk(16'h0C00 + 16'(r)));
      tick();
      check($sformatf("ej_idle%0d", r), ej_valid, 0);
      check($sformatf("ej_idle_flit%0d", r), ej_flit, '0);
    end

    // Overflow on port 1
    ej_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      portl1_co = mk(16'h0D00 + 16'(i));
      tick();
    end
    portl1_co = '0;
    #1 check("ovf_drop", drop_cnt, 2);
    ej_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("ovf_read%0d", i), ej_flit, mk(16'h0D00 + 16'(i)));
      tick();
    end
    check("ovf_empty", ej_valid, 0);

    // Full ejection FIFO 0 popped while a new flit arrives
    ej_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      portl0_co = mk(16'h0E00 + 16'(i));
      tick();
    end
    ej_ready = 1'b1;
    portl0_co = mk(16'h0E04);
    tick();
    portl0_co = '0;
    #1 check("fullpop_drop", drop_cnt, 2);
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("fullpop_read%0d", i), ej_flit, mk(16'h0E00 + 16'(i)));
      tick();
    end
    check("fullpop_empty", ej_valid, 0);

    // Async reset with data in both directions
    ej_ready = 1'b0;
    portl0_co = mk(16'h0F00);
    inj_flit = mk(16'h0F10); inj_port = 1'b0; inj_valid = 1'b1;
    tick();
    portl0_co = '0;
    inj_flit = mk(16'h0F11); inj_port = 1'b1;
    tick();
    inj_valid = 1'b0;
    #1 check("pre_rst_ej", ej_valid, 1);
    check("pre_rst_ci1", portl1_ci, mk(16'h0F11));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ci0", portl0_ci, '0);
    check("mid_rst_ci1", portl1_ci, '0);
    check("mid_rst_ej_flit", ej_flit, '0);
    check("mid_rst_ej_valid", ej_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    #1 rst = 1'b0;
    ej_ready = 1'b1;
    tick();
    check("post_rst_ej", ej_valid, 0);
    check("post_rst_ci0", portl0_ci, '0);
    check("post_rst_ready", inj_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
